// File: rtl/risc_pkg.sv
// Shared types for the 16-bit RISC core: opcodes, ALU selects, PC sources, controller states.
package risc_pkg;

  localparam int unsigned ALU_W = 3;
  localparam int unsigned PCS_W = 2;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_NOT   = 4'h2,
    OP_SHL   = 4'h3,
    OP_SHR   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_SLT   = 4'h7,
    OP_LD    = 4'h8,
    OP_ST    = 4'h9,
    OP_BEQ   = 4'hA,
    OP_BNE   = 4'hB,
    OP_JMP   = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_NOT = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SHL = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SHR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b101;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [PCS_W-1:0] PC_INC = 2'b00;
  localparam logic [PCS_W-1:0] PC_BR  = 2'b01;
  localparam logic [PCS_W-1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

endpackage

// File: rtl/risc_ctrl_decode.sv
// Combinational opcode classifier feeding the multi-cycle controller.
module risc_ctrl_decode
  import risc_pkg::*;
(
  input  logic [3:0]       opc,
  output logic             is_alu,
  output logic             is_ld,
  output logic             is_st,
  output logic             is_br,
  output logic             br_ne,
  output logic             is_jmp,
  output logic             is_halt,
  output logic             is_illegal,
  output logic [ALU_W-1:0] alu_op
);

  always_comb begin
    is_alu     = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_br      = 1'b0;
    br_ne      = 1'b0;
    is_jmp     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = opc[2:0];
    case (opcode_e'(opc))
      OP_ADD, OP_SUB, OP_NOT, OP_SHL,
      OP_SHR, OP_AND, OP_OR, OP_SLT: is_alu = 1'b1;
      OP_LD:   is_ld = 1'b1;
      OP_ST:   is_st = 1'b1;
      OP_BEQ:  is_br = 1'b1;
      OP_BNE: begin
        is_br = 1'b1;
        br_ne = 1'b1;
      end
      OP_JMP:  is_jmp  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/risc_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with bounded memory waits.
// Build option RISC_ILLEGAL_TRAP_EN: illegal opcodes trap to ERR and raise illegal_op.
module risc_multicycle_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned OPC_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [15:0]      instr,
  input  logic             zero,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [PCS_W-1:0] pc_src,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             alu_src_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             halted,
`ifdef RISC_ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic             bus_err
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  state_e             state_q, state_d, boundary;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_c;
  logic               is_alu, is_ld, is_st, is_br, br_ne, is_jmp, is_halt, is_illegal;
  logic [ALU_W-1:0]   alu_op;
  logic               illegal_q;
  logic               unused_instr;

  assign unused_instr = ^instr[15-OPC_W:0];

  risc_ctrl_decode u_decode (
    .opc        (4'(instr[15 -: OPC_W])),
    .is_alu     (is_alu),
    .is_ld      (is_ld),
    .is_st      (is_st),
    .is_br      (is_br),
    .br_ne      (br_ne),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (alu_op)
  );

  // Counter holds the number of cycles already spent waiting; ready on the last allowed cycle still wins.
  assign timeout_c = TO_EN && (cnt_q == CNT_W'(CNT_LIM));
  assign boundary  = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RISC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (state_q == S_DECODE && is_illegal) illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_INC;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    alu_src_b = 1'b0;
    alu_ctrl  = ALU_ADD;
    halted    = 1'b0;
    bus_err   = 1'b0;
`ifdef RISC_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_c) state_d = S_ERR;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_DECODE: begin
        if (is_jmp) begin
          pc_we   = 1'b1;
          pc_src  = PC_JMP;
          state_d = boundary;
        end else if (is_halt) state_d = S_HALT;
        else if (is_illegal) begin
`ifdef RISC_ILLEGAL_TRAP_EN
          state_d = S_ERR;
`else
          pc_we   = 1'b1;
          state_d = boundary;
`endif
        end else state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu) begin
          alu_ctrl = alu_op;
          state_d  = S_WB;
        end else if (is_ld || is_st) begin
          alu_src_b = 1'b1;
          state_d   = S_MEM;
        end else if (is_br) begin
          alu_ctrl = ALU_SUB;
          pc_we    = 1'b1;
          pc_src   = (zero ^ br_ne) ? PC_BR : PC_INC;
          state_d  = boundary;
        end else state_d = boundary;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ready) begin
          if (is_ld) state_d = S_WB;
          else begin
            pc_we   = 1'b1;
            state_d = boundary;
          end
        end else if (timeout_c) state_d = S_ERR;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = is_ld;
        pc_we   = 1'b1;
        state_d = boundary;
      end
      S_HALT: halted = 1'b1;
      S_ERR: begin
        bus_err = ~illegal_q;
`ifdef RISC_ILLEGAL_TRAP_EN
        illegal_op = illegal_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc_multicycle_ctrl.sv
// Cycle-accurate scoreboard bench for risc_multicycle_ctrl (TIMEOUT_CYCLES = 16).
module tb_risc_multicycle_ctrl;

  localparam logic [15:0] IMRQ = 16'h8000;
  localparam logic [15:0] DMRQ = 16'h4000;
  localparam logic [15:0] DMWE = 16'h2000;
  localparam logic [15:0] IRWE = 16'h1000;
  localparam logic [15:0] PCWE = 16'h0800;
  localparam logic [15:0] PJMP = 16'h0400;
  localparam logic [15:0] PBR  = 16'h0200;
  localparam logic [15:0] RFWE = 16'h0100;
  localparam logic [15:0] WBS  = 16'h0080;
  localparam logic [15:0] SRCB = 16'h0040;
  localparam logic [15:0] AOP1 = 16'h0008;
  localparam logic [15:0] HLT  = 16'h0004;
  localparam logic [15:0] BERR = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0, zero = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel, alu_src_b, halted, bus_err;
  logic [1:0]  pc_src;
  logic [2:0]  alu_ctrl;
  logic        illegal_op;
  logic [15:0] obs;

  typedef struct {
    logic        run;
    logic        ir;
    logic        dr;
    logic        z;
    logic [15:0] ins;
    logic [15:0] exp;
  } step_t;

  step_t       stim_q[$];
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  risc_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .OPC_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .instr      (instr),
    .zero       (zero),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .halted     (halted),
`ifdef RISC_ILLEGAL_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .bus_err    (bus_err)
  );

`ifndef RISC_ILLEGAL_TRAP_EN
  assign illegal_op = 1'b0;
`endif

  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, rf_we, wb_sel,
                alu_src_b, alu_ctrl, halted, bus_err, illegal_op};

  task automatic add(input logic r, input logic ir, input logic dr, input logic z,
                     input logic [15:0] ins, input logic [15:0] e);
    step_t s;
    s.run = r; s.ir = ir; s.dr = dr; s.z = z; s.ins = ins; s.exp = e;
    stim_q.push_back(s);
  endtask

  task automatic drive(input step_t s);
    run = s.run; imem_ready = s.ir; dmem_ready = s.dr; zero = s.z; instr = s.ins;
    exp_q.push_back(s.exp);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1; instr = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = 16'h0000; total++;
      if (obs !== e) begin bad++; $display("FAIL reset cyc%0d: got=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_alu();
    step_t s; logic [15:0] e, ins;
    for (int op = 0; op < 8; op++) begin
      apply_reset();
      ins = 16'(op) << 12;
      add(1, 1, 0, 0, ins, 16'h0000);
      add(1, 1, 0, 0, ins, IMRQ | IRWE);
      add(1, 1, 0, 0, ins, 16'h0000);
      add(1, 1, 0, 0, ins, 16'(op << 3));
      add(1, 1, 0, 0, ins, RFWE | PCWE);
      add(1, 1, 0, 0, ins, IMRQ | IRWE);
      for (int c = 0; stim_q.size() > 0; c++) begin
        s = stim_q.pop_front(); drive(s);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL alu op%0d cyc%0d: got=%h exp=%h", op, c, obs, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_mem();
    step_t s; logic [15:0] e;
    apply_reset();
    add(1, 1, 0, 0, 16'h8123, 16'h0000);
    add(1, 1, 0, 0, 16'h8123, IMRQ | IRWE);
    add(1, 0, 0, 0, 16'h8123, 16'h0000);
    add(1, 0, 0, 0, 16'h8123, SRCB);
    add(1, 0, 0, 0, 16'h8123, DMRQ);
    add(1, 0, 0, 0, 16'h8123, DMRQ);
    add(1, 0, 0, 0, 16'h8123, DMRQ);
    add(1, 0, 1, 0, 16'h8123, DMRQ);
    add(1, 0, 0, 0, 16'h8123, RFWE | WBS | PCWE);
    add(1, 1, 0, 0, 16'h9000, IMRQ | IRWE);
    add(1, 0, 0, 0, 16'h9000, 16'h0000);
    add(1, 0, 0, 0, 16'h9000, SRCB);
    add(1, 0, 1, 0, 16'h9000, DMRQ | DMWE | PCWE);
    add(0, 0, 0, 0, 16'h9000, IMRQ);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ldst cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t s; logic [15:0] e, ins;
    logic [15:0] br_ins [4] = '{16'hA000, 16'hA000, 16'hB000, 16'hB000};
    logic        br_z   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] br_exp [4] = '{PCWE | PBR | AOP1, PCWE | AOP1, PCWE | PBR | AOP1, PCWE | AOP1};
    for (int k = 0; k < 4; k++) begin
      apply_reset();
      ins = br_ins[k];
      add(1, 1, 0, br_z[k], ins, 16'h0000);
      add(1, 1, 0, br_z[k], ins, IMRQ | IRWE);
      add(1, 1, 0, br_z[k], ins, 16'h0000);
      add(1, 1, 0, br_z[k], ins, br_exp[k]);
      add(1, 1, 0, br_z[k], ins, IMRQ | IRWE);
      for (int c = 0; stim_q.size() > 0; c++) begin
        s = stim_q.pop_front(); drive(s);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL branch%0d cyc%0d: got=%h exp=%h", k, c, obs, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jmp_run();
    step_t s; logic [15:0] e;
    apply_reset();
    add(1, 1, 0, 0, 16'hC000, 16'h0000);
    add(1, 1, 0, 0, 16'hC000, IMRQ | IRWE);
    add(1, 1, 0, 0, 16'hC000, PCWE | PJMP);
    add(1, 1, 0, 0, 16'hC000, IMRQ | IRWE);
    add(0, 1, 0, 0, 16'hC000, PCWE | PJMP);
    add(0, 1, 0, 0, 16'hC000, 16'h0000);
    add(1, 1, 0, 0, 16'hC000, 16'h0000);
    add(1, 1, 0, 0, 16'hC000, IMRQ | IRWE);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL jmp_run cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s; logic [15:0] e;
    apply_reset();
    add(1, 0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 16'h0000, IMRQ);
    for (int i = 0; i < 3; i++) add(1'(i), 1, 0, 0, 16'h0000, BERR);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL fetch_timeout cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    apply_reset();
    add(1, 0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 16'h0000, IMRQ);
    add(1, 1, 0, 0, 16'h0000, IMRQ | IRWE);
    add(1, 0, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 0, 16'h0000, RFWE | PCWE);
    add(1, 0, 0, 0, 16'h0000, IMRQ);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL ready_at_limit cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    apply_reset();
    add(1, 1, 0, 0, 16'h8000, 16'h0000);
    add(1, 1, 0, 0, 16'h8000, IMRQ | IRWE);
    add(1, 0, 0, 0, 16'h8000, 16'h0000);
    add(1, 0, 0, 0, 16'h8000, SRCB);
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 16'h8000, DMRQ);
    add(1, 0, 1, 0, 16'h8000, BERR);
    add(1, 1, 1, 0, 16'h8000, BERR);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL mem_timeout cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_reset();
    step_t s; logic [15:0] e;
    apply_reset();
    add(1, 1, 0, 0, 16'hF000, 16'h0000);
    add(1, 1, 0, 0, 16'hF000, IMRQ | IRWE);
    add(1, 1, 0, 0, 16'hF000, 16'h0000);
    for (int i = 0; i < 5; i++) add(1'(i + 1), 1, 0, 0, 16'hF000, HLT);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL halt cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    apply_reset();
    add(1, 1, 0, 0, 16'h8000, 16'h0000);
    add(1, 1, 0, 0, 16'h8000, IMRQ | IRWE);
    add(1, 0, 0, 0, 16'h8000, 16'h0000);
    add(1, 0, 0, 0, 16'h8000, SRCB);
    add(1, 0, 0, 0, 16'h8000, DMRQ);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL mid_ld cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    e = 16'h0000; total++;
    if (obs !== e) begin bad++; $display("FAIL async_reset: got=%h exp=%h", obs, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    add(1, 1, 0, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 0, 16'h0000, IMRQ | IRWE);
    add(1, 1, 0, 0, 16'h0000, 16'h0000);
    for (int c = 0; stim_q.size() > 0; c++) begin
      s = stim_q.pop_front(); drive(s);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL restart cyc%0d: got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t s; logic [15:0] e, ins;
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      ins = (k == 0) ? 16'hD000 : 16'hE000;
      add(1, 1, 0, 0, ins, 16'h0000);
      add(1, 1, 0, 0, ins, IMRQ | IRWE);
`ifdef RISC_ILLEGAL_TRAP_EN
      add(1, 1, 0, 0, ins, 16'h0000);
      add(1, 1, 0, 0, ins, ILL);
      add(0, 1, 0, 0, ins, ILL);
      add(1, 1, 0, 0, 16'h0000, ILL);
`else
      add(1, 1, 0, 0, ins, PCWE);
      add(1, 1, 0, 0, ins, IMRQ | IRWE);
      add(1, 1, 0, 0, 16'h0000, 16'h0000);
      add(1, 1, 0, 0, 16'h0000, 16'h0000);
`endif
      for (int c = 0; stim_q.size() > 0; c++) begin
        s = stim_q.pop_front(); drive(s);
        @(negedge clk);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL illegal%0d cyc%0d: got=%h exp=%h", k, c, obs, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jmp_run();
    test_timeout();
    test_halt_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
